// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the multicycle core controller and its execute-stage ALU.
interface multicycle_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         alu_control;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   hi;
  logic               zero;

  modport master (
    output start, a, b, alu_control, shamt,
    input  busy, done, result, hi, zero
  );

  modport slave (
    input  start, a, b, alu_control, shamt,
    output busy, done, result, hi, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Clocked ALU: single-cycle logic/arith ops plus iterative unsigned multiply
// (shift-add, LSB first) and restoring unsigned divide (MSB first).
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   hi;
  logic               zero;

  logic [WIDTH-1:0]   sc_result;
  logic [WIDTH-1:0]   sc_hi;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem_n;
  logic [WIDTH-1:0]   div_q_n;

  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    case (bus.alu_control)
      OP_AND:  sc_result = bus.a & bus.b;
      OP_OR:   sc_result = bus.a | bus.b;
      OP_ADD:  sc_result = bus.a + bus.b;
      OP_SUB:  sc_result = bus.a - bus.b;
      OP_NOR:  sc_result = ~(bus.a | bus.b);
      OP_SLT:  sc_result = (bus.a < bus.b) ? WIDTH'(1) : '0;
      OP_SLL:  sc_result = bus.b << bus.shamt;
      OP_SRL:  sc_result = bus.b >> bus.shamt;
      OP_DIVU: begin
        // Only reached with b == 0; nonzero divisors take the iterative path.
        sc_result = '1;
        sc_hi     = bus.a;
      end
      default: ;
    endcase
  end

  // Multiply: acc_hi accumulates partial product, acc_lo shifts out multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  always_comb begin
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = ~div_diff[WIDTH];
    div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_n   = {acc_lo[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      zero   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (bus.start) begin
            if (bus.alu_control == OP_MUL) begin
              opnd   <= bus.a;
              acc_hi <= '0;
              acc_lo <= bus.b;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_MUL;
            end else if (bus.alu_control == OP_DIVU && bus.b != '0) begin
              opnd   <= bus.b;
              acc_hi <= '0;
              acc_lo <= bus.a;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_DIV;
            end else begin
              result <= sc_result;
              hi     <= sc_hi;
              zero   <= (sc_result == '0);
              done   <= 1'b1;
              state  <= S_FIN;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == LAST_ITER) begin
            result <= mul_lo_n;
            hi     <= mul_hi_n;
            zero   <= (mul_lo_n == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_FIN;
          end
        end
        S_DIV: begin
          acc_hi <= div_rem_n;
          acc_lo <= div_q_n;
          cnt    <= cnt + SHAMT_W'(1);
          if (cnt == LAST_ITER) begin
            result <= div_q_n;
            hi     <= div_rem_n;
            zero   <= (div_q_n == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.hi     = hi;
  assign bus.zero   = zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised self-checking bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  multicycle_alu_if #(.WIDTH(W)) bus ();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [4:0] s, output logic [W-1:0] r, output logic [W-1:0] h,
                                output int lat);
    logic [63:0] p;
    r = '0; h = '0; lat = 1;
    case (op)
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0111: r = (x < y) ? 32'd1 : 32'd0;
      4'b0011: r = y << s;
      4'b1011: r = y >> s;
      4'b1111: begin
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0]; h = p[63:32]; lat = W + 1;
      end
      4'b1110: begin
        if (y == 0) begin r = '1; h = x; end
        else begin r = x / y; h = x % y; lat = W + 1; end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [4:0] s, input bit hold);
    logic [W-1:0] er, eh;
    int el, lat, busy_n;
    bit seen;
    model(op, x, y, s, er, eh, el);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = op; bus.a = x; bus.b = y; bus.shamt = s;
    lat = 0; busy_n = 0; seen = 0;
    while (!seen && lat < 3 * W) begin
      @(negedge clk);
      lat++;
      bus.a = $urandom; bus.b = $urandom; bus.shamt = 5'($urandom);
      bus.alu_control = 4'($urandom);
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1;
      bus.start = hold && bus.busy && !bus.done;
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_busycyc"}, 64'(busy_n), 64'(el - 1));
    check({tag, "_result"}, 64'(bus.result), 64'(er));
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_zero"}, 64'(bus.zero), 64'(er == 0));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_hold"}, 64'(bus.result), 64'(er));
  endtask

  logic [3:0] ops [12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111,
                           4'b0011, 4'b1011, 4'b1111, 4'b1110, 4'b0101, 4'b1000};

  initial begin
    int done_cnt;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_control = '0; bus.shamt = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    reset = 1'b0;

    run_op("add", 4'b0010, 32'd4, 32'd1, 5'd0, 0);
    run_op("sub", 4'b0110, 32'd4, 32'd4, 5'd0, 0);
    run_op("slt", 4'b0111, 32'd1, 32'd2, 5'd0, 0);
    run_op("nor", 4'b1100, 32'd0, 32'd0, 5'd0, 0);
    run_op("sll", 4'b0011, 32'd0, 32'd1, 5'd31, 0);
    run_op("srl", 4'b1011, 32'd0, 32'h8000_0000, 5'd31, 0);
    run_op("mul_max", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1);
    run_op("divu", 4'b1110, 32'd100, 32'd7, 5'd0, 1);
    run_op("div0", 4'b1110, 32'd9, 32'd0, 5'd0, 0);
    run_op("unk", 4'b0101, 32'd3, 32'd5, 5'd0, 0);

    // A start issued in the done cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = 4'b0010; bus.a = 32'd4; bus.b = 32'd1;
    @(negedge clk);
    check("chain1_done", 64'(bus.done), 64'd1);
    check("chain1_result", 64'(bus.result), 64'd5);
    bus.alu_control = 4'b0110; bus.a = 32'd10; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("chain2_done", 64'(bus.done), 64'd1);
    check("chain2_result", 64'(bus.result), 64'd7);

    // Reset mid-multiply aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = 4'b1111; bus.a = 32'd123; bus.b = 32'd456;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_zero", 64'(bus.zero), 64'd1);
    done_cnt = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
      if (mode == 2) rb = '0;
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 11)], ra, rb, 5'($urandom),
             bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit alu_control encodings and adds iterative unsigned multiply (full 2*WIDTH product) and unsigned divide (quotient plus remainder).
- Sits in the execute stage of the multicycle core; the controller issues one operation with start and stalls until done.
- Single-cycle ops finish in one clock; MUL and DIVU take WIDTH+1 clocks.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2 and at least 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; a, b, alu_control and shamt are sampled on this edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_control  input  4  operation select.
- shamt  input  SHAMT_W  shift amount.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result, hi and zero are valid from this cycle on.
- result  output  WIDTH  primary result (low product or quotient).
- hi  output  WIDTH  secondary result (high product or remainder); 0 for other ops.
- zero  output  1  high when result == 0.

Behaviour:
- Opcodes:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, NOR 1100.
  - SLT 0111: unsigned a<b gives 1, else 0.
  - SLL 0011: b<<shamt. SRL 1011: b>>shamt (logical).
  - MUL 1111: unsigned, {hi,result} = a*b.
  - DIVU 1110: result = a/b, hi = a%b.
  - Any other code: result = 0, hi = 0, one-cycle completion.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Reset: on the edge where reset=1, state <= IDLE; busy, done, result, hi <= 0; zero <= 1. Reset wins over start in the same cycle and aborts any operation in flight; no done is produced for the aborted op.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - With start=1 and a single-cycle op: compute and register result/hi, go to FIN. done pulses on the next cycle, so latency is 1.
  - With start=1 and MUL: latch operands, clear accumulator, counter <= 0, go to MUL.
  - With start=1 and DIVU where b != 0: latch operands, clear remainder, counter <= 0, go to DIV.
  - With start=1 and DIVU where b == 0: result <= all ones, hi <= a, go to FIN (latency 1).
- MUL: shift-add, one multiplier bit per cycle, LSB first, WIDTH iterations. After the last iteration, load {hi,result} and go to FIN.
- DIV: restoring division, one quotient bit per cycle, MSB first, WIDTH iterations, then go to FIN.
- FIN: done=1 for exactly this cycle, then return to IDLE. In FIN, busy=0, so a start in this cycle is accepted.
- Latency from the start edge to the done cycle: 1 for single-cycle ops, WIDTH+1 for MUL/DIVU.
- busy=1 in MUL and DIV states only. start while busy is ignored: no capture and no queuing.
- Input changes after the start edge do not affect the operation in progress.
- result, hi and zero hold their last values until the next completion or reset. zero is registered together with result.

Test Plan:
- Reset, then ADD a=4, b=1 -> done one cycle after start; result=5, hi=0, zero=0, busy never asserted.
- SUB a=4, b=4, then SLT a=1, b=2, then NOR a=0, b=0 -> result 0 with zero=1; then 1; then 0xFFFFFFFF.
- SLL b=1, shamt=31, then SRL b=0x80000000, shamt=31 -> 0x80000000, then 1.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, done on cycle 33; result=0x00000001, hi=0xFFFFFFFE. Back-to-back start held high during busy -> ignored.
- DIVU a=100, b=7 -> done after 33 cycles with result=14, hi=2. DIVU a=9, b=0 -> latency 1; result=0xFFFFFFFF, hi=9.
- Start MUL, assert reset at cycle 10 -> next cycle busy=0, done=0, result=0, zero=1, and no done pulse follows. Unknown opcode 0101 -> result=0, done after 1 cycle.
